loproc_mul_seq: RTL and testbench
=================================

Name: loproc_mul_seq

Overview:
- Parametrised, handshaked successor to the LoPROC add-and-shift multiplier.
- Skips zero bits of the multiplier operand: one accumulate step per set bit, located by a priority encoder and cleared each cycle.
- Adds signed/unsigned modes (uu, ss, su), a valid/ready handshake on both sides, and output holding under back-pressure.
- Sits in the LoPROC execute stage and returns a full 2*DATA_WIDTH product as out_h:out_l.

Parameters:
- DATA_WIDTH, 32, operand width in bits; any power of two from 8 to 64.
- DATA_LOG2, $clog2(DATA_WIDTH), width of the bit-index bus; derived, never overridden.

Ports:
- mul_clk  input  1  clock; all logic on rising edge.
- mul_rst  input  1  reset, synchronous and active-high.
- in1  input  DATA_WIDTH  multiplicand.
- in2  input  DATA_WIDTH  multiplier; its set bits are iterated.
- mode  input  2  00 unsigned x unsigned; 01 signed x signed; 10 signed in1 x unsigned in2; 11 behaves as 00.
- valid_in  input  1  operands and mode are valid.
- ready_out  output  1  block can accept; high only in IDLE.
- out_l  output  DATA_WIDTH  product low half.
- out_h  output  DATA_WIDTH  product high half.
- valid_out  output  1  product valid; held until consumed.
- ready_in  input  1  downstream accepts the product.
- busy  output  1  high in CALC or FIX.

Behaviour:
- Reset (mul_rst high at an edge, from any state, including mid-operation):
  - state to IDLE; out_l, out_h, valid_out, busy to 0; ready_out to 1.
  - Accumulator, magnitude registers and sign flag cleared.
  - The in-flight operation is discarded and no valid_out is produced for it.
- Accept: valid_in & ready_out at edge k captures the operands as follows.
  - mag1 = |in1| if in1 is signed under mode, else in1. mag2 likewise for in2.
  - Magnitudes are DATA_WIDTH-bit unsigned; the most negative input yields 2^(DATA_WIDTH-1) with no overflow.
  - neg = sign(in1 as signed) XOR sign(in2 as signed).
  - acc = 0 (2*DATA_WIDTH bits).
  - If either operand is 0: out_h:out_l = 0 and state goes to DONE at edge k, so valid_out is high the cycle after acceptance. Otherwise state goes to CALC.
- CALC, one edge per set bit of mag2:
  - idx = lowest set bit of mag2.
  - acc += zero_extend(mag1) << idx.
  - mag2 clears bit idx.
  - When the cleared mag2 becomes 0, the next state is FIX.
- FIX, one edge: out_h:out_l = neg ? (0 - acc) : acc, taken modulo 2^(2*DATA_WIDTH); state goes to DONE.
- Latency: with n = popcount(mag2), valid_out rises n+1 edges after the accept edge (edges k+1..k+n are CALC, edge k+n+1 is FIX). Worst case is DATA_WIDTH+1.
- DONE:
  - valid_out = 1, and out_l/out_h stay stable while ready_in = 0, for any number of cycles.
  - valid_out & ready_in at an edge: state goes to IDLE and valid_out to 0. The output registers keep the last product.
- valid_in outside IDLE is ignored; it is not queued. A new accept is possible at the earliest the cycle after the DONE handshake.
- Input changes after acceptance do not affect the result.
- busy = (state == CALC) | (state == FIX). ready_out = (state == IDLE). Both are decoded from registered state.
- mode 11 produces exactly the same result and timing as mode 00.
- No arithmetic exceptions; the full-width product always fits in 2*DATA_WIDTH bits.

Test Plan:
- Unsigned, DATA_WIDTH=32, mode 00, in1=0x0000_0007, in2=0x0000_0005 -> popcount 2, valid_out 3 cycles after accept; out_h=0, out_l=0x23.
- Zero shortcut: in1=0x1234_5678, in2=0 -> valid_out the cycle after accept, product 0, busy never high; repeat with in1=0.
- Signed, mode 01: in1=0xFFFF_FFFD (-3), in2=0x0000_0004 -> out_h=0xFFFF_FFFF, out_l=0xFFFF_FFF4. Also in1=in2=0x8000_0000 -> out_h=0x4000_0000, out_l=0.
- Signed x unsigned, mode 10: in1=0xFFFF_FFFF, in2=0xFFFF_FFFF -> 32 CALC cycles, valid_out 33 cycles after accept; out_h=0xFFFF_FFFF, out_l=0x0000_0001. Same operands in mode 00 -> out_h=0xFFFF_FFFE, out_l=0x0000_0001.
- Back-pressure: hold ready_in=0 for 10 cycles in DONE -> valid_out and product stable, ready_out=0, a valid_in pulse is ignored. Raise ready_in -> next cycle IDLE, ready_out=1.
- Mid-operation reset: assert mul_rst 5 cycles into a 0xFFFF_FFFF x 0xFFFF_FFFF op -> next cycle all outputs 0, ready_out=1, no valid_out. A following 6x7 op yields 0x2A.

Source files
------------

// File: rtl/loproc_mul_seq.sv
// loproc_mul_seq: sequential add-and-shift multiplier that visits only the set
// bits of the multiplier magnitude, with unsigned/signed/mixed modes and
// valid/ready handshakes on both operand and product sides.
module loproc_mul_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  mul_clk,
  input  logic                  mul_rst,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  input  logic [1:0]            mode,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic [DATA_WIDTH-1:0] out_l,
  output logic [DATA_WIDTH-1:0] out_h,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  busy,
  output logic [1:0]            dbg_state_o
);

  localparam int DATA_LOG2 = $clog2(DATA_WIDTH);
  localparam int PW        = 2 * DATA_WIDTH;

  // Handshake: an operand transfer happens on an edge where valid_in & ready_out,
  // a product transfer on an edge where valid_out & ready_in. Once valid_out is
  // raised it and the product stay unchanged until that product transfer.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_WIDTH-1:0] mag1_q, mag1_d;
  logic [DATA_WIDTH-1:0] mag2_q, mag2_d;
  logic                  neg_q, neg_d;
  logic [PW-1:0]         acc_q, acc_d;
  logic [DATA_WIDTH-1:0] out_l_q, out_l_d;
  logic [DATA_WIDTH-1:0] out_h_q, out_h_d;

  // Operand conditioning: which inputs are signed, their magnitudes and product sign.
  logic                  sgn1, sgn2;
  logic                  neg1, neg2;
  logic [DATA_WIDTH-1:0] mag_in1, mag_in2;
  logic [DATA_LOG2-1:0]  idx;
  logic [PW-1:0]         addend;
  logic [DATA_WIDTH-1:0] mag2_clr;
  logic [PW-1:0]         fixed;

  // Magnitudes: two's complement negate when the operand is signed and negative;
  // the most negative value maps onto 2^(DATA_WIDTH-1), which still fits unsigned.
  always_comb begin
    sgn1    = (mode == 2'b01) || (mode == 2'b10);
    sgn2    = (mode == 2'b01);
    neg1    = sgn1 & in1[DATA_WIDTH-1];
    neg2    = sgn2 & in2[DATA_WIDTH-1];
    mag_in1 = neg1 ? (~in1 + 1'b1) : in1;
    mag_in2 = neg2 ? (~in2 + 1'b1) : in2;
  end

  // Priority encoder: index of the lowest set bit of the remaining multiplier.
  always_comb begin
    idx = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (mag2_q[i]) idx = DATA_LOG2'(i);
    end
  end

  // Datapath for one accumulate step and the final sign fix-up.
  always_comb begin
    addend   = {{DATA_WIDTH{1'b0}}, mag1_q} << idx;
    mag2_clr = mag2_q & ~({{(DATA_WIDTH-1){1'b0}}, 1'b1} << idx);
    fixed    = neg_q ? ({PW{1'b0}} - acc_q) : acc_q;
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d = state_q;
    mag1_d  = mag1_q;
    mag2_d  = mag2_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    out_l_d = out_l_q;
    out_h_d = out_h_q;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          mag1_d = mag_in1;
          mag2_d = mag_in2;
          neg_d  = neg1 ^ neg2;
          acc_d  = '0;
          if ((in1 == '0) || (in2 == '0)) begin
            out_l_d = '0;
            out_h_d = '0;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d  = acc_q + addend;
        mag2_d = mag2_clr;
        if (mag2_clr == '0) state_d = FIX;
      end
      FIX: begin
        out_l_d = fixed[DATA_WIDTH-1:0];
        out_h_d = fixed[PW-1:DATA_WIDTH];
        state_d = DONE;
      end
      DONE: begin
        if (ready_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge mul_clk) begin
    if (mul_rst) begin
      state_q <= IDLE;
      mag1_q  <= '0;
      mag2_q  <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      out_l_q <= '0;
      out_h_q <= '0;
    end else begin
      state_q <= state_d;
      mag1_q  <= mag1_d;
      mag2_q  <= mag2_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      out_l_q <= out_l_d;
      out_h_q <= out_h_d;
    end
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    ready_out   = (state_q == IDLE);
    valid_out   = (state_q == DONE);
    busy        = (state_q == CALC) || (state_q == FIX);
    out_l       = out_l_q;
    out_h       = out_h_q;
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_loproc_mul_seq.sv
// tb_loproc_mul_seq: directed and random operations compared against an
// arithmetic reference product and a popcount-based latency model.
module tb_loproc_mul_seq;

  localparam int W = 32;

  logic          clk;
  logic          mul_rst;
  logic [W-1:0]  in1, in2;
  logic [1:0]    mode;
  logic          valid_in;
  logic          ready_out;
  logic [W-1:0]  out_l, out_h;
  logic          valid_out;
  logic          ready_in;
  logic          busy;
  logic [1:0]    dbg_state;

  int errors = 0;
  int checks = 0;

  logic [2*W-1:0] exp_q[$];

  loproc_mul_seq #(.DATA_WIDTH(W)) dut (
    .mul_clk    (clk),
    .mul_rst    (mul_rst),
    .in1        (in1),
    .in2        (in2),
    .mode       (mode),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .out_l      (out_l),
    .out_h      (out_h),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .busy       (busy),
    .dbg_state_o(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product: sign- or zero-extend each operand per mode, multiply.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] m);
    logic signed [2*W+1:0] sa, sb, p;
    sa = (m == 2'b01 || m == 2'b10) ? {{(W+2){a[W-1]}}, a} : {{(W+2){1'b0}}, a};
    sb = (m == 2'b01) ? {{(W+2){b[W-1]}}, b} : {{(W+2){1'b0}}, b};
    p  = sa * sb;
    return p[2*W-1:0];
  endfunction

  // Edges after the accept edge until valid_out is visible.
  function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [1:0] m);
    logic [W-1:0] mag;
    if (a == '0 || b == '0) return 0;
    mag = (m == 2'b01 && b[W-1]) ? (-b) : b;
    return $countones(mag) + 1;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (!ready_out && n < 100) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!ready_out) begin
      errors++;
      $display("FAIL wait_idle: ready_out=%0b required 1 within 100 cycles", ready_out);
    end
  endtask

  // Full operation: accept, latency, product, optional back-pressure, drain.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m,
                        input int hold, input bit pulse);
    logic [2*W-1:0] exp_p, got;
    int exp_lat, lat;
    bit seen_busy, busy_gap;
    exp_q.push_back(ref_mul(a, b, m));
    exp_lat = ref_lat(a, b, m);
    wait_idle();
    in1 = a; in2 = b; mode = m; valid_in = 1'b1; ready_in = 1'b0;
    @(posedge clk); #1;
    valid_in = 1'b0;
    in1 = $urandom; in2 = $urandom; mode = 2'($urandom_range(0, 3));
    lat = 0; seen_busy = 0; busy_gap = 0;
    while (!valid_out && lat < W + 4) begin
      if (busy) seen_busy = 1; else busy_gap = 1;
      @(posedge clk); #1; lat++;
    end
    exp_p = exp_q.pop_front();
    got = {out_h, out_l};
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL latency %h*%h m%0d: got %0d edges required %0d", a, b, m, lat, exp_lat);
    end
    checks++;
    if (got !== exp_p) begin
      errors++;
      $display("FAIL product %h*%h m%0d: got %h required %h", a, b, m, got, exp_p);
    end
    checks++;
    if (seen_busy !== (exp_lat > 0) || busy_gap) begin
      errors++;
      $display("FAIL busy_window %h*%h: seen=%0b gap=%0b required seen=%0b gap=0",
               a, b, seen_busy, busy_gap, exp_lat > 0);
    end
    checks++;
    if (ready_out !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_flags: ready_out=%0b busy=%0b required 0 0", ready_out, busy);
    end
    for (int i = 0; i < hold; i++) begin
      if (pulse && i == 3) begin
        in1 = 32'd3; in2 = 32'd3; mode = 2'b00; valid_in = 1'b1;
      end
      @(posedge clk); #1;
      valid_in = 1'b0;
      checks++;
      if (valid_out !== 1'b1 || {out_h, out_l} !== exp_p || ready_out !== 1'b0) begin
        errors++;
        $display("FAIL hold cycle %0d: valid_out=%0b prod=%h ready_out=%0b required 1 %h 0",
                 i, valid_out, {out_h, out_l}, ready_out, exp_p);
      end
    end
    ready_in = 1'b1;
    @(posedge clk); #1;
    ready_in = 1'b0;
    checks++;
    if (valid_out !== 1'b0 || ready_out !== 1'b1 || {out_h, out_l} !== exp_p) begin
      errors++;
      $display("FAIL drain: valid_out=%0b ready_out=%0b prod=%h required 0 1 %h",
               valid_out, ready_out, {out_h, out_l}, exp_p);
    end
  endtask

  task automatic test_reset();
    mul_rst = 1'b1; valid_in = 1'b0; ready_in = 1'b0;
    in1 = '0; in2 = '0; mode = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_l !== '0 || out_h !== '0 || valid_out !== 1'b0 || busy !== 1'b0 || ready_out !== 1'b1) begin
      errors++;
      $display("FAIL reset: out=%h valid_out=%0b busy=%0b ready_out=%0b required 0 0 0 1",
               {out_h, out_l}, valid_out, busy, ready_out);
    end
    mul_rst = 1'b0;
  endtask

  task automatic test_directed();
    run_op(32'h0000_0007, 32'h0000_0005, 2'b00, 0, 0);
    run_op(32'hFFFF_FFFD, 32'h0000_0004, 2'b01, 0, 0);
    run_op(32'h8000_0000, 32'h8000_0000, 2'b01, 0, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 0, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 0, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 0, 0);
    run_op(32'h0000_0005, 32'hFFFF_FFFE, 2'b01, 0, 0);
    run_op(32'h8000_0000, 32'h0000_0003, 2'b10, 0, 0);
  endtask

  task automatic test_zero();
    run_op(32'h1234_5678, 32'h0000_0000, 2'b00, 0, 0);
    run_op(32'h0000_0000, 32'h1234_5678, 2'b01, 0, 0);
  endtask

  task automatic test_backpressure();
    run_op(32'h0000_1234, 32'h0000_00F1, 2'b00, 10, 1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) run_op($urandom, 32'($urandom_range(1, 255)), 2'b01, 0, 0);
  endtask

  task automatic test_mid_reset();
    bit leaked = 0;
    wait_idle();
    in1 = 32'hFFFF_FFFF; in2 = 32'hFFFF_FFFF; mode = 2'b00; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    mul_rst = 1'b1;
    @(posedge clk); #1;
    mul_rst = 1'b0;
    checks++;
    if (out_l !== '0 || out_h !== '0 || valid_out !== 1'b0 || busy !== 1'b0 || ready_out !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: out=%h valid_out=%0b busy=%0b ready_out=%0b required 0 0 0 1",
               {out_h, out_l}, valid_out, busy, ready_out);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (valid_out || busy) leaked = 1;
    end
    checks++;
    if (leaked) begin
      errors++;
      $display("FAIL mid_reset_discard: leaked=1 required 0");
    end
    run_op(32'd6, 32'd7, 2'b00, 0, 0);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: a = 32'($urandom_range(0, 15));
        1: a = 32'h8000_0000;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: b = 32'($urandom_range(0, 15));
        1: b = 32'h8000_0000 | 32'($urandom_range(0, 3));
        default: b = $urandom;
      endcase
      run_op(a, b, 2'($urandom_range(0, 3)), $urandom_range(0, 3), 0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
